l2_nway_instr_cache: RTL and testbench
======================================

Name: l2_nway_instr_cache

Overview:
- Parametrised set-associative, read-only instruction cache with multi-word lines, true-LRU replacement, and a sequential refill FSM towards the next memory level.
- Sits between the fetch stage (requester) and the L3/main-memory instruction port.
- Successor to the fixed 4-way, 1-word-per-line L2 instruction cache. Adds configurable ways, sets and line size, a refill handshake, stall signalling, reset and flush.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width. Fixed at 32; the byte offset is always 2 bits.
- NUM_SETS, 64, number of sets. Must be a power of 2, ≥2.
- NUM_WAYS, 4, associativity. Must be a power of 2, ≥2.
- LINE_WORDS, 4, words per line. Must be a power of 2, ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  fetch request valid.
- addr_i  in  ADDR_WIDTH  fetch byte address. Bits [1:0] are ignored. Must be held stable while stall_o=1.
- resp_valid_o  out  1  resp_data_o holds the word for addr_i this cycle.
- resp_data_o  out  DATA_WIDTH  fetched word. Zero when resp_valid_o=0.
- hit_o  out  1  lookup hit this cycle; only asserted in IDLE.
- stall_o  out  1  cache is busy; the requester must hold its request.
- mem_req_o  out  1  word read request to the next level.
- mem_addr_o  out  ADDR_WIDTH  word-aligned refill address.
- mem_valid_i  in  1  next level returns one word this cycle.
- mem_data_i  in  DATA_WIDTH  refill word.
- flush_i  in  1  invalidate the whole cache.

Behaviour:
- Address split: word offset = addr[2+WOFF-1:2], where WOFF=clog2(LINE_WORDS), and 0 bits when LINE_WORDS=1. Index = next clog2(NUM_SETS) bits. Tag = the remaining upper bits.
- Per-way storage: valid bit, tag, LINE_WORDS data words, and an age of clog2(NUM_WAYS) bits.
- Reset:
  - all valid bits cleared; in set s, way w gets age=w;
  - FSM goes to IDLE, word counter to 0;
  - all outputs 0.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - Lookup is combinational. Hit when a valid way has a matching tag; the lowest index wins if several match.
  - req_valid_i and hit: resp_valid_o=1, hit_o=1, resp_data_o=line word at the offset, all in the same cycle (0-cycle latency). LRU is updated on the next edge.
  - req_valid_i and miss: stall_o=1 combinationally. Victim and line base address are latched, counter is set to 0, next state REFILL.
  - Victim selection: the lowest-index invalid way; otherwise the way with the maximum age, lowest index on a tie.
- REFILL:
  - mem_req_o=1, mem_addr_o = {line base, counter, 2'b00}, stall_o=1.
  - Each mem_valid_i writes mem_data_i into victim word[counter], and the counter increments.
  - On the last word: write tag, set valid, update LRU, next state RESPOND.
  - mem_valid_i outside REFILL is ignored.
- RESPOND: a one-cycle state. resp_valid_o=1, resp_data_o=requested word, hit_o=0, stall_o=0. Next state IDLE.
  - Total miss latency = LINE_WORDS memory beats + 1 cycle, plus the memory wait cycles.
- LRU update (true LRU; ages in a set always form a permutation of 0..NUM_WAYS-1): on access to way a with old age k, set age[a]=0 and increment every way with age<k. Applied on hit and on refill completion.
- flush_i:
  - In IDLE: clears all valid bits on the next edge; ages are untouched. If req_valid_i is asserted in the same cycle, flush wins: stall_o=1, no response, and the request is serviced from the next cycle.
  - In REFILL/RESPOND: flush is latched as pending and applied on the first IDLE cycle. The line being refilled still completes and responds, then is invalidated.
- rst during REFILL: the refill is abandoned with no partial-line valid. mem_req_o drops on the next cycle.
- Address wrap: refill addresses never cross the line boundary; the counter wraps within the line only.

Optional Feature:
- Macro L2_CACHE_PERF_COUNTERS_EN.
- Defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0]. They are cleared by rst and saturate at 0xFFFFFFFF.
  - hit_count_o increments on each IDLE hit.
  - miss_count_o increments on each IDLE miss acceptance.
  - Flush-blocked cycles are not counted.
- Undefined: neither the ports nor the logic exist.

Test Plan:
- Cold miss: rst, then request 0x0000_1004, with memory returning 0xA0..0xA3 for words 0..3 over 4 beats.
  - Required: mem_addr_o = 0x1000, 0x1004, 0x1008, 0x100C.
  - Then a RESPOND cycle with data 0xA1.
  - A repeat request to 0x1008 hits with data 0xA2 in the same cycle.
- Fill a set: NUM_WAYS=4, NUM_SETS=64, LINE_WORDS=4 gives a set stride of 0x400. Fill set 0 with tags for 0x0000, 0x0400, 0x0800, 0x0C00.
  - Re-access 0x0000, then miss on 0x1000.
  - Required: the victim is the 0x0400 line, so 0x0400 misses and 0x0000 still hits.
- Flush and request collide in IDLE: assert flush_i with a request to a cached address.
  - Required: no response that cycle; the next cycle misses and triggers a refill.
- Flush during REFILL at beat 2.
  - Required: the refill completes and RESPOND delivers correct data.
  - A subsequent access to the same line misses.
- rst at refill beat 1.
  - Required: next cycle mem_req_o=0, stall_o=0; a re-request misses; no stale data is returned.
- With L2_CACHE_PERF_COUNTERS_EN defined: 3 hits and 2 misses.
  - Required: hit_count_o=3, miss_count_o=2; both are 0 after rst.

Source files
------------

// File: rtl/l2_nway_instr_cache.sv
// l2_nway_instr_cache: set-associative, read-only instruction cache with
// multi-word lines, true-LRU replacement and a sequential refill engine.
// Optional hit/miss performance counters are enabled by defining
// L2_CACHE_PERF_COUNTERS_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | combinational lookup; hits answer in the same cycle
// REFILL  | fetching the victim line word by word from the next level
// RESPOND | one-cycle delivery of the requested word after a refill
module l2_nway_instr_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  hit_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  flush_i
`ifdef L2_CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);

    localparam int WOFF   = $clog2(LINE_WORDS);
    localparam int CW     = (WOFF > 0) ? WOFF : 1;
    localparam int IDXW   = $clog2(NUM_SETS);
    localparam int WAYW   = $clog2(NUM_WAYS);
    localparam int IDX_SH = 2 + WOFF;
    localparam int TAG_SH = 2 + WOFF + IDXW;
    localparam int TAGW   = ADDR_WIDTH - TAG_SH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    typedef logic [NUM_WAYS-1:0][WAYW-1:0] ages_t;
    typedef logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAYW-1:0] all_ages_t;

    // After reset every set starts with way w holding age w.
    function automatic all_ages_t init_ages();
        all_ages_t r;
        r = '0;
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                r[s][w] = WAYW'(w);
            end
        end
        return r;
    endfunction

    localparam all_ages_t AGE_INIT = init_ages();

    // Accessed way becomes youngest; ways younger than it age by one,
    // so the ages stay a permutation of 0..NUM_WAYS-1.
    function automatic ages_t lru_next(input ages_t ages, input logic [WAYW-1:0] a);
        ages_t r;
        r = ages;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAYW'(w) == a) begin
                r[w] = '0;
            end else if (ages[w] < ages[a]) begin
                r[w] = ages[w] + 1'b1;
            end
        end
        return r;
    endfunction

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
    all_ages_t                         age_q;
    logic [TAGW-1:0]                   tag_q  [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]             data_q [NUM_SETS][NUM_WAYS][LINE_WORDS];

    logic [1:0]      state_q;
    logic [CW-1:0]   cnt_q;
    logic [WAYW-1:0] victim_q;
    logic [IDXW-1:0] r_idx_q;
    logic [TAGW-1:0] r_tag_q;
    logic [CW-1:0]   r_off_q;
    logic            flush_pend_q;

    logic [CW-1:0]   lk_off;
    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [WAYW-1:0] hit_way;
    logic [WAYW-1:0] vic_way;
    logic [WAYW-1:0] max_way;
    logic            vic_found;
    logic            flush_eff;
    logic            last_beat;
    logic [ADDR_WIDTH-1:0] word_part;

    assign lk_off    = (WOFF > 0) ? CW'(addr_i >> 2) : '0;
    assign lk_idx    = IDXW'(addr_i >> IDX_SH);
    assign lk_tag    = TAGW'(addr_i >> TAG_SH);
    assign flush_eff = flush_i | flush_pend_q;
    assign last_beat = (cnt_q == CW'(LINE_WORDS - 1));
    assign word_part = (WOFF > 0) ? (ADDR_WIDTH'(cnt_q) << 2) : '0;

    // Tag compare across the indexed set; lowest matching way wins.
    always_comb begin
        lk_hit  = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit  = 1'b1;
                hit_way = WAYW'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the oldest way (lowest index on a tie).
    always_comb begin
        vic_found = 1'b0;
        vic_way   = '0;
        max_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!vic_found && !valid_q[lk_idx][w]) begin
                vic_found = 1'b1;
                vic_way   = WAYW'(w);
            end
            if (age_q[lk_idx][w] > age_q[lk_idx][max_way]) begin
                max_way = WAYW'(w);
            end
        end
        if (!vic_found) begin
            vic_way = max_way;
        end
    end

    // Requester and memory-side outputs decoded from the current state.
    always_comb begin
        resp_valid_o = 1'b0;
        resp_data_o  = '0;
        hit_o        = 1'b0;
        stall_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (flush_eff) begin
                        stall_o = 1'b1;
                    end else if (lk_hit) begin
                        resp_valid_o = 1'b1;
                        hit_o        = 1'b1;
                        resp_data_o  = data_q[lk_idx][hit_way][lk_off];
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
            S_REFILL: begin
                mem_req_o  = 1'b1;
                stall_o    = 1'b1;
                mem_addr_o = (ADDR_WIDTH'(r_tag_q) << TAG_SH)
                           | (ADDR_WIDTH'(r_idx_q) << IDX_SH)
                           | word_part;
            end
            S_RESPOND: begin
                resp_valid_o = 1'b1;
                resp_data_o  = data_q[r_idx_q][victim_q][r_off_q];
            end
            default: ;
        endcase
    end

    // Control state, tags, valid bits, LRU ages and pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            victim_q     <= '0;
            r_idx_q      <= '0;
            r_tag_q      <= '0;
            r_off_q      <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            age_q        <= AGE_INIT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush_eff) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (req_valid_i) begin
                        if (lk_hit) begin
                            age_q[lk_idx] <= lru_next(age_q[lk_idx], hit_way);
                        end else begin
                            victim_q <= vic_way;
                            r_idx_q  <= lk_idx;
                            r_tag_q  <= lk_tag;
                            r_off_q  <= lk_off;
                            cnt_q    <= '0;
                            state_q  <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_valid_i) begin
                        if (last_beat) begin
                            tag_q[r_idx_q][victim_q]   <= r_tag_q;
                            valid_q[r_idx_q][victim_q] <= 1'b1;
                            age_q[r_idx_q]             <= lru_next(age_q[r_idx_q], victim_q);
                            cnt_q                      <= '0;
                            state_q                    <= S_RESPOND;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_RESPOND: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line data array; only written by refill beats.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_REFILL) && mem_valid_i) begin
            data_q[r_idx_q][victim_q][cnt_q] <= mem_data_i;
        end
    end

`ifdef L2_CACHE_PERF_COUNTERS_EN
    // Saturating hit/miss counters for accepted IDLE lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if ((state_q == S_IDLE) && req_valid_i && !flush_eff) begin
            if (lk_hit) begin
                if (hit_count_o != 32'hFFFF_FFFF) hit_count_o <= hit_count_o + 32'd1;
            end else begin
                if (miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_nway_instr_cache.sv
// Self-checking bench for l2_nway_instr_cache (default parameters).
// Reference model: per-set recency list of cached line addresses plus a
// fixed backing-memory function.
module tb_l2_nway_instr_cache;

    localparam int NS = 64;
    localparam int NW = 4;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        flush;
`ifdef L2_CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    l2_nway_instr_cache dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .addr_i       (addr),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .hit_o        (hit),
        .stall_o      (stall),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_valid_i  (mem_valid),
        .mem_data_i   (mem_data),
        .flush_i      (flush)
`ifdef L2_CACHE_PERF_COUNTERS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rec_line [NS][NW];
    int          rec_n    [NS];

    typedef struct {
        bit          do_rst;
        logic [31:0] addr;
        bit          exp_hit;
        bit          chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Backing memory: line 0x1000 holds 0xA0..0xA3, everything else a hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if ((w >> 4) == 32'h100) return 32'hA0 + ((w >> 2) & 32'h3);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h3F);
    endfunction

    function automatic int model_find(input logic [31:0] a);
        int s;
        logic [31:0] line;
        s = set_of(a);
        line = a & 32'hFFFF_FFF0;
        for (int i = 0; i < rec_n[s]; i++) begin
            if (rec_line[s][i] == line) return i;
        end
        return -1;
    endfunction

    function automatic void model_touch(input int s, input int pos);
        logic [31:0] t;
        t = rec_line[s][pos];
        for (int i = pos; i > 0; i--) rec_line[s][i] = rec_line[s][i-1];
        rec_line[s][0] = t;
    endfunction

    function automatic void model_insert(input int s, input logic [31:0] line);
        if (rec_n[s] < NW) rec_n[s]++;
        for (int i = rec_n[s] - 1; i > 0; i--) rec_line[s][i] = rec_line[s][i-1];
        rec_line[s][0] = line;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) rec_n[s] = 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; addr = '0; mem_valid = 1'b0; mem_data = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // One fetch; expectation comes from the model. flush_beat >= 0 pulses
    // flush_i during the refill once that many beats have been delivered.
    task automatic access(input logic [31:0] a, input int flush_beat,
                          output logic got_hit, output logic [31:0] got_data);
        int s, pos, beats, guard;
        logic [31:0] base, expd;
        bit flushed;
        s = set_of(a);
        base = a & 32'hFFFF_FFF0;
        expd = mem_word(a);
        pos = model_find(a);
        req_valid = 1'b1; addr = a;
        mem_valid = 1'($urandom % 2); mem_data = $urandom;
        @(negedge clk);
        got_hit = hit; got_data = resp_data;
        if (pos >= 0) begin
            chk("hit_hit_o", 32'(hit), 32'd1);
            chk("hit_resp_valid", 32'(resp_valid), 32'd1);
            chk("hit_data", resp_data, expd);
            chk("hit_stall", 32'(stall), 32'd0);
            model_touch(s, pos);
            @(posedge clk); #1;
            req_valid = 1'b0; mem_valid = 1'b0;
        end else begin
            chk("miss_hit_o", 32'(hit), 32'd0);
            chk("miss_stall", 32'(stall), 32'd1);
            chk("miss_resp_valid", 32'(resp_valid), 32'd0);
            chk("miss_resp_data", resp_data, 32'd0);
            beats = 0; guard = 0; flushed = 0;
            while (beats < LW && guard < 100) begin
                @(posedge clk); #1;
                guard++;
                chk("refill_mem_req", 32'(mem_req), 32'd1);
                chk("refill_addr", mem_addr, base + 32'(4 * beats));
                flush = (!flushed && beats == flush_beat);
                if (flush) flushed = 1;
                mem_valid = (($urandom % 3) != 0);
                mem_data = mem_valid ? mem_word(base + 32'(4 * beats)) : $urandom;
                @(negedge clk);
                chk("refill_stall", 32'(stall), 32'd1);
                if (mem_valid) beats++;
            end
            if (guard >= 100) chk("refill_timeout", 32'(beats), 32'(LW));
            @(posedge clk); #1;
            mem_valid = 1'b0; flush = 1'b0;
            @(negedge clk);
            chk("respond_valid", 32'(resp_valid), 32'd1);
            chk("respond_hit_o", 32'(hit), 32'd0);
            chk("respond_stall", 32'(stall), 32'd0);
            chk("respond_mem_req", 32'(mem_req), 32'd0);
            chk("respond_data", resp_data, expd);
            got_data = resp_data;
            model_insert(s, base);
            if (flushed) model_clear();
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (flushed) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Flush collides with a request in IDLE: blocked cycle, then a miss.
    task automatic collide(input logic [31:0] a);
        logic h;
        logic [31:0] d;
        req_valid = 1'b1; addr = a; flush = 1'b1;
        @(negedge clk);
        chk("collide_resp_valid", 32'(resp_valid), 32'd0);
        chk("collide_hit_o", 32'(hit), 32'd0);
        chk("collide_stall", 32'(stall), 32'd1);
        chk("collide_resp_data", resp_data, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        access(a, -1, h, d);
        chk("collide_then_miss", 32'(h), 32'd0);
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        logic [31:0] d;
        logic [31:0] ra;

        vt[0]  = '{1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'h0000_00A1};
        vt[1]  = '{1'b0, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_00A2};
        vt[2]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h0000_0400, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h0000_0800, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 32'h0000_0C00, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_00A0};
        vt[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 32'h0000_0400, 1'b0, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h0000_0C00, 1'b1, 1'b0, 32'h0};
        vt[11] = '{1'b0, 32'h0000_0800, 1'b0, 1'b0, 32'h0};

        do_reset();
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_hit_o", 32'(hit), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            if (vt[i].do_rst) do_reset();
            access(vt[i].addr, -1, h, d);
            chk($sformatf("vec%0d_hit", i), 32'(h), 32'(vt[i].exp_hit));
            if (vt[i].chk_data) chk($sformatf("vec%0d_data", i), d, vt[i].exp_data);
        end

        // Flush colliding with a request to a cached line.
        access(32'h0000_2010, -1, h, d);
        access(32'h0000_2014, -1, h, d);
        chk("pre_collide_hit", 32'(h), 32'd1);
        collide(32'h0000_2014);

        // Flush during refill at beat 2; line completes, then is invalidated.
        access(32'h0000_3028, 2, h, d);
        chk("flush_refill_data", d, mem_word(32'h0000_3028));
        access(32'h0000_302C, -1, h, d);
        chk("flush_refill_then_miss", 32'(h), 32'd0);

        // Reset at refill beat 1.
        do_reset();
        req_valid = 1'b1; addr = 32'h0000_4034;
        @(negedge clk);
        chk("rstref_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_data = mem_word(32'h0000_4030);
        @(negedge clk);
        chk("rstref_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0; mem_valid = 1'b0; req_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rstref_mem_req_low", 32'(mem_req), 32'd0);
        chk("rstref_stall_low", 32'(stall), 32'd0);
        chk("rstref_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        access(32'h0000_4034, -1, h, d);
        chk("rstref_rereq_miss", 32'(h), 32'd0);
        chk("rstref_rereq_data", d, mem_word(32'h0000_4034));

`ifdef L2_CACHE_PERF_COUNTERS_EN
        do_reset();
        chk("perf_hits_rst", hit_count, 32'd0);
        chk("perf_miss_rst", miss_count, 32'd0);
        access(32'h0000_5000, -1, h, d);
        access(32'h0000_5000, -1, h, d);
        access(32'h0000_5004, -1, h, d);
        access(32'h0000_6000, -1, h, d);
        access(32'h0000_6008, -1, h, d);
        chk("perf_hits", hit_count, 32'd3);
        chk("perf_misses", miss_count, 32'd2);
        do_reset();
        chk("perf_hits_rst2", hit_count, 32'd0);
        chk("perf_miss_rst2", miss_count, 32'd0);
`endif

        // Randomized traffic over a small pool so sets overflow and hit.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom % 25);
            ra = (32'($urandom % 8) << 10) | (32'($urandom % 4) << 4) | (32'($urandom % 4) << 2);
            if (r == 0) flush_idle();
            else if (r == 1) collide(ra);
            else access(ra, (r == 2) ? 2 : -1, h, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
